down_counter_5bit: RTL and testbench

Loadable 5-bit down-counter/timer built around a borrow-chain decrement, the subtract-direction counterpart to the team's 5-bit ripple-carry adder datapath in the counter library. A value is loaded, a start request launches the countdown, and each enabled cycle decrements the count by one. A one-cycle `done` pulse marks the 1→0 terminal event. The block runs either one-shot or auto-reload (periodic tick generator), and serves as the timing source for counter-based control blocks.

---
 rtl/down_counter_5bit.sv | 113 +++++++++++
 tb/tb_down_counter_5bit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/down_counter_5bit.sv
// Loadable down-counter/timer: borrow-chain decrement, one-shot or auto-reload,
// single-cycle done pulse on the 1->0 terminal event.
module down_counter_5bit #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             reload_mode,
    output logic [WIDTH-1:0] cnt,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] rld_reg, rld_next;
    logic             done_reg, done_next;

    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] borrow;
    logic             cnt_is_zero;
    logic             cnt_is_one;
    logic             rld_is_zero;

    // Ripple-borrow subtract-by-one: a borrow propagates up through low zeros.
    assign borrow[0] = 1'b1;
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_borrow
        assign dec[gi] = cnt_reg[gi] ^ borrow[gi];
        if (gi < WIDTH - 1) begin : g_prop
            assign borrow[gi+1] = borrow[gi] & ~cnt_reg[gi];
        end
    end

    assign cnt_is_zero = (cnt_reg == '0);
    assign cnt_is_one  = (cnt_reg == WIDTH'(1));
    assign rld_is_zero = (rld_reg == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            rld_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rld_reg   <= rld_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rld_next   = rld_reg;
        done_next  = 1'b0;
        if (load) begin
            cnt_next   = load_val;
            rld_next   = load_val;
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    // A zero-length timer completes at once without entering RUN.
                    if (start) begin
                        if (cnt_is_zero) begin
                            done_next = 1'b1;
                        end else begin
                            state_next = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_next = S_IDLE;
                    end else if (en) begin
                        if (cnt_is_one) begin
                            done_next = 1'b1;
                            if (reload_mode && !rld_is_zero) begin
                                cnt_next = rld_reg;
                            end else begin
                                cnt_next   = '0;
                                state_next = S_IDLE;
                            end
                        end else begin
                            cnt_next = dec;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt  = cnt_reg;
        zero = cnt_is_zero;
        busy = (state_reg == S_RUN);
        done = done_reg;
    end

endmodule

// File: tb/tb_down_counter_5bit.sv
// Bench for down_counter_5bit: directed vector table, hand sequences for long
// corner cases, then random stimulus against a behavioural timer model.
module tb_down_counter_5bit;

    logic       clk = 1'b0;
    logic       rst, load, start, stop, en, reload_mode;
    logic [4:0] load_val;
    logic [4:0] cnt;
    logic       zero, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    down_counter_5bit #(.WIDTH(5)) dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .en(en), .reload_mode(reload_mode),
        .cnt(cnt), .zero(zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, load;
        logic [4:0] lv;
        logic       start, stop, en, rm;
        logic [4:0] e_cnt;
        logic       e_busy, e_done;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic r, logic ld, logic [4:0] lv,
                                logic st, logic sp, logic e, logic rm,
                                logic [4:0] ec, logic eb, logic ed);
        vec_t v;
        v.name = name; v.rst = r; v.load = ld; v.lv = lv; v.start = st;
        v.stop = sp; v.en = e; v.rm = rm; v.e_cnt = ec; v.e_busy = eb; v.e_done = ed;
        return v;
    endfunction

    task automatic check(string name, logic [4:0] ec, logic eb, logic ed);
        n_checks += 4;
        if (cnt !== ec) begin
            n_fail++;
            $display("FAIL %s cnt: got %0d expected %0d", name, cnt, ec);
        end
        if (busy !== eb) begin
            n_fail++;
            $display("FAIL %s busy: got %0b expected %0b", name, busy, eb);
        end
        if (done !== ed) begin
            n_fail++;
            $display("FAIL %s done: got %0b expected %0b", name, done, ed);
        end
        if (zero !== (ec == 5'd0)) begin
            n_fail++;
            $display("FAIL %s zero: got %0b expected %0b", name, zero, (ec == 5'd0));
        end
    endtask

    task automatic apply(vec_t v);
        rst = v.rst; load = v.load; load_val = v.lv; start = v.start;
        stop = v.stop; en = v.en; reload_mode = v.rm;
        @(posedge clk);
        #1;
        check(v.name, v.e_cnt, v.e_busy, v.e_done);
        $display("vec %-10s rst=%0b ld=%0b lv=%0d st=%0b sp=%0b en=%0b rm=%0b -> cnt=%0d busy=%0b done=%0b zero=%0b",
                 v.name, v.rst, v.load, v.lv, v.start, v.stop, v.en, v.rm, cnt, busy, done, zero);
    endtask

    // Behavioural timer model
    int m_cnt, m_rld;
    bit m_run, m_done;

    task automatic model_step(bit r, bit ld, int lv, bit st, bit sp, bit e, bit rm);
        m_done = 0;
        if (r) begin
            m_cnt = 0; m_rld = 0; m_run = 0;
        end else if (ld) begin
            m_cnt = lv; m_rld = lv; m_run = 0;
        end else if (m_run) begin
            if (sp) m_run = 0;
            else if (e) begin
                if (m_cnt == 1) begin
                    m_done = 1;
                    if (rm && m_rld != 0) m_cnt = m_rld;
                    else begin m_cnt = 0; m_run = 0; end
                end else m_cnt = (m_cnt - 1) % 32;
            end
        end else if (st) begin
            if (m_cnt == 0) m_done = 1;
            else m_run = 1;
        end
    endtask

    initial begin
        vec_t v;
        rst = 1; load = 0; load_val = 0; start = 0; stop = 0; en = 0; reload_mode = 0;

        // one-shot 5
        vecs.push_back(mk("reset",   1,0,0, 0,0,0,0,  0,0,0));
        vecs.push_back(mk("load5",   0,1,5, 0,0,1,0,  5,0,0));
        vecs.push_back(mk("start5",  0,0,0, 1,0,1,0,  5,1,0));
        vecs.push_back(mk("os4",     0,0,0, 0,0,1,0,  4,1,0));
        vecs.push_back(mk("os3",     0,0,0, 0,0,1,0,  3,1,0));
        vecs.push_back(mk("os2",     0,0,0, 0,0,1,0,  2,1,0));
        vecs.push_back(mk("os1",     0,0,0, 0,0,1,0,  1,1,0));
        vecs.push_back(mk("os0",     0,0,0, 0,0,1,0,  0,0,1));
        vecs.push_back(mk("osidle",  0,0,0, 0,0,1,0,  0,0,0));
        // auto-reload 3
        vecs.push_back(mk("load3",   0,1,3, 0,0,1,1,  3,0,0));
        vecs.push_back(mk("ar_st",   0,0,0, 1,0,1,1,  3,1,0));
        vecs.push_back(mk("ar2",     0,0,0, 0,0,1,1,  2,1,0));
        vecs.push_back(mk("ar1",     0,0,0, 0,0,1,1,  1,1,0));
        vecs.push_back(mk("ar_rl",   0,0,0, 1,0,1,1,  3,1,1));
        vecs.push_back(mk("ar2b",    0,0,0, 0,0,1,1,  2,1,0));
        vecs.push_back(mk("ar1b",    0,0,0, 0,0,1,1,  1,1,0));
        vecs.push_back(mk("ar_rl2",  0,0,0, 0,0,1,1,  3,1,1));
        vecs.push_back(mk("ar_stop", 0,0,0, 0,1,1,1,  3,0,0));
        // en toggling with 4
        vecs.push_back(mk("load4",   0,1,4, 0,0,0,0,  4,0,0));
        vecs.push_back(mk("en_idle", 0,0,0, 0,0,1,0,  4,0,0));
        vecs.push_back(mk("tg_st",   0,0,0, 1,0,0,0,  4,1,0));
        vecs.push_back(mk("tg3",     0,0,0, 0,0,1,0,  3,1,0));
        vecs.push_back(mk("tg3h",    0,0,0, 0,0,0,0,  3,1,0));
        vecs.push_back(mk("tg2",     0,0,0, 0,0,1,0,  2,1,0));
        vecs.push_back(mk("tg2h",    0,0,0, 1,0,0,0,  2,1,0));
        vecs.push_back(mk("tg1",     0,0,0, 0,0,1,0,  1,1,0));
        vecs.push_back(mk("tg1h",    0,0,0, 0,0,0,0,  1,1,0));
        vecs.push_back(mk("tg0",     0,0,0, 0,0,1,0,  0,0,1));
        // stop at 2 then resume
        vecs.push_back(mk("load5b",  0,1,5, 0,0,1,0,  5,0,0));
        vecs.push_back(mk("sp_st",   0,0,0, 1,0,1,0,  5,1,0));
        vecs.push_back(mk("sp4",     0,0,0, 0,0,1,0,  4,1,0));
        vecs.push_back(mk("sp3",     0,0,0, 0,0,1,0,  3,1,0));
        vecs.push_back(mk("sp2",     0,0,0, 0,0,1,0,  2,1,0));
        vecs.push_back(mk("stop2",   0,0,0, 0,1,1,0,  2,0,0));
        vecs.push_back(mk("stopidl", 0,0,0, 0,1,1,0,  2,0,0));
        vecs.push_back(mk("resume",  0,0,0, 1,0,1,0,  2,1,0));
        vecs.push_back(mk("rs1",     0,0,0, 0,0,1,0,  1,1,0));
        vecs.push_back(mk("rs0",     0,0,0, 0,0,1,0,  0,0,1));
        // zero-length timer, load+start collision, load clears done
        vecs.push_back(mk("load0",   0,1,0, 0,0,1,0,  0,0,0));
        vecs.push_back(mk("start0",  0,0,0, 1,0,1,0,  0,0,1));
        vecs.push_back(mk("after0",  0,0,0, 0,0,1,0,  0,0,0));
        vecs.push_back(mk("ld_st",   0,1,7, 1,0,1,0,  7,0,0));
        vecs.push_back(mk("ld_st2",  0,0,0, 0,0,1,0,  7,0,0));
        vecs.push_back(mk("ar1_ld",  0,1,1, 0,0,1,1,  1,0,0));
        vecs.push_back(mk("ar1_st",  0,0,0, 1,0,1,1,  1,1,0));
        vecs.push_back(mk("ar1_a",   0,0,0, 0,0,1,1,  1,1,1));
        vecs.push_back(mk("ar1_b",   0,0,0, 0,0,1,1,  1,1,1));
        vecs.push_back(mk("ar1_os",  0,0,0, 0,0,1,0,  0,0,1));
        vecs.push_back(mk("ar1_end", 0,0,0, 0,0,1,0,  0,0,0));

        foreach (vecs[i]) apply(vecs[i]);

        // Full-range countdown: 31 enabled edges to done
        apply(mk("load31", 0,1,31, 0,0,1,0, 31,0,0));
        apply(mk("st31",   0,0,0,  1,0,1,0, 31,1,0));
        for (int i = 1; i <= 30; i++)
            apply(mk("fr", 0,0,0, 0,0,1,0, 5'(31 - i), 1, 0));
        apply(mk("fr_done", 0,0,0, 0,0,1,0, 0,0,1));

        // Reset at cnt=17 during auto-reload, then start without load
        apply(mk("load20", 0,1,20, 0,0,1,1, 20,0,0));
        apply(mk("st20",   0,0,0,  1,0,1,1, 20,1,0));
        apply(mk("c19",    0,0,0,  0,0,1,1, 19,1,0));
        apply(mk("c18",    0,0,0,  0,0,1,1, 18,1,0));
        apply(mk("c17",    0,0,0,  0,0,1,1, 17,1,0));
        apply(mk("rst17",  1,0,0,  0,0,1,1, 0,0,0));
        apply(mk("st_rz",  0,0,0,  1,0,1,1, 0,0,1));
        apply(mk("st_rz2", 0,0,0,  0,0,1,1, 0,0,0));

        // Random stimulus against model
        apply(mk("rreset", 1,0,0, 0,0,0,0, 0,0,0));
        m_cnt = 0; m_rld = 0; m_run = 0; m_done = 0;
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 99) < 1);
            load        = ($urandom_range(0, 99) < 6);
            load_val    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            start       = ($urandom_range(0, 99) < 25);
            stop        = ($urandom_range(0, 99) < 4);
            en          = ($urandom_range(0, 99) < 75);
            reload_mode = ($urandom_range(0, 99) < 50);
            model_step(rst, load, int'(load_val), start, stop, en, reload_mode);
            @(posedge clk);
            #1;
            check("rand", 5'(m_cnt), m_run, m_done);
            $display("rnd %0d rst=%0b ld=%0b lv=%0d st=%0b sp=%0b en=%0b rm=%0b -> cnt=%0d busy=%0b done=%0b (model %0d %0b %0b)",
                     c, rst, load, load_val, start, stop, en, reload_mode, cnt, busy, done, m_cnt, m_run, m_done);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
